add_op_arbiter: RTL and testbench

- Shares one combinational AddOp adder between NUM_REQUESTERS independent requesters.
- Fair round-robin arbitration; operands captured into registers; adder result registered; returned on a shared response channel tagged with requester ID.
- Sits between the ALU front-end ports and a single AddOp implementation instance, which is reached through the add_lhs/add_rhs/add_result ports.

---
 rtl/add_op_arbiter.sv | 146 ++++++++++++++
 tb/tb_add_op_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_op_arbiter.sv
// add_op_arbiter
//   Shares one external combinational adder between NUM_REQUESTERS requesters.
//   A round-robin arbiter accepts one request at a time. The winner's operands
//   are registered and drive the adder. The sum is registered and returned on a
//   single response channel, tagged with the index of the requester that owns it.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot or zero)
//   req_lhs/req_rhs     packed operands, requester i at [i*OPERAND_WIDTH +: OPERAND_WIDTH]
//   add_lhs/add_rhs     registered operands sent to the adder
//   add_result          combinational sum returned by the adder
//   rsp_valid/rsp_ready response handshake; rsp_id and rsp_result are held until accepted
//   busy                high while an operation is in flight
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and accepts the winner
// EXEC  | adder evaluating the captured operands; sum is registered
// RESP  | response presented, held until rsp_ready
module add_op_arbiter #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQUESTERS-1:0]               req_valid,
  output logic [NUM_REQUESTERS-1:0]               req_ready,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH-1:0] req_rhs,
  output logic [OPERAND_WIDTH-1:0]                add_lhs,
  output logic [OPERAND_WIDTH-1:0]                add_rhs,
  input  logic [OPERAND_WIDTH-1:0]                add_result,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [ID_WIDTH-1:0]                     rsp_id,
  output logic [OPERAND_WIDTH-1:0]                rsp_result,
  output logic                                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]      grant_id_q, grant_id_d;
  logic [OPERAND_WIDTH-1:0] lhs_q, lhs_d;
  logic [OPERAND_WIDTH-1:0] rhs_q, rhs_d;
  logic [OPERAND_WIDTH-1:0] result_q, result_d;

  logic [ID_WIDTH-1:0]      cand;
  logic [ID_WIDTH-1:0]      winner;
  logic                     found;
  logic [OPERAND_WIDTH-1:0] win_lhs, win_rhs;
  logic [ID_WIDTH-1:0]      next_ptr;

  // Search starting at rr_ptr, wrapping at NUM_REQUESTERS-1 back to 0.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQUESTERS);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_lhs = '0;
    win_rhs = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (winner == ID_WIDTH'(i)) begin
        win_lhs = req_lhs[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        win_rhs = req_rhs[i*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

  assign next_ptr = (grant_id_q == ID_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    result_d   = result_q;
    req_ready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          // Gated by rst_n so no requester sees an accept while reset is held.
          req_ready[winner] = rst_n;
          grant_id_d        = winner;
          lhs_d             = win_lhs;
          rhs_d             = win_rhs;
          state_d           = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = add_result;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      result_q   <= result_d;
    end
  end

  assign add_lhs    = lhs_q;
  assign add_rhs    = rhs_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = grant_id_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add_op_arbiter.sv
module tb_add_op_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_lhs = '0;
  logic [N*W-1:0] req_rhs = '0;
  logic [W-1:0]   add_lhs, add_rhs, add_result;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           busy;

  always #5 clk = ~clk;

  // The shared adder the block fronts.
  assign add_result = add_lhs + add_rhs;

  add_op_arbiter #(.OPERAND_WIDTH(W), .NUM_REQUESTERS(N), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs),
    .add_lhs(add_lhs), .add_rhs(add_rhs), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one outstanding op, its age in cycles,
  // the fairness pointer, and the operands last handed to the adder.
  bit           m_out = 1'b0;
  int           m_age = 0;
  int           m_id = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_sum = '0;
  logic [W-1:0] m_last_lhs = '0;
  logic [W-1:0] m_last_rhs = '0;

  int           cyc = 0;
  int           grants[$];
  int           grant_cyc[$];
  int           rsp_count = 0;
  int           last_rsp_id = -1;
  logic [W-1:0] last_rsp_result = '0;

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [N*W-1:0] rnd_pack();
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = rnd_op();
    return p;
  endfunction

  function automatic void model_reset();
    m_out      = 1'b0;
    m_age      = 0;
    m_ptr      = 0;
    m_last_lhs = '0;
    m_last_rhs = '0;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] l, input logic [N*W-1:0] r,
                      input logic rr);
    int           exp_id;
    logic [N-1:0] exp_ready;
    logic [W-1:0] a, b;
    @(negedge clk);
    req_valid = v;
    req_lhs   = l;
    req_rhs   = r;
    rsp_ready = rr;
    #1;
    exp_id    = -1;
    exp_ready = '0;
    if (rst_n && !m_out)
      for (int k = 0; k < N; k++)
        if (exp_id < 0 && v[(m_ptr + k) % N]) exp_id = (m_ptr + k) % N;
    if (exp_id >= 0) exp_ready[exp_id] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, m_out);
    chk("rsp_valid", rsp_valid, m_out && m_age >= 2);
    chk("add_lhs", add_lhs, m_last_lhs);
    chk("add_rhs", add_rhs, m_last_rhs);
    if (m_out && m_age >= 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_sum);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] && v[i]) begin
        grants.push_back(i);
        grant_cyc.push_back(cyc);
      end
    if (rsp_valid && rr) begin
      rsp_count++;
      last_rsp_id     = rsp_id;
      last_rsp_result = rsp_result;
    end
    if (m_out) begin
      if (m_age >= 2 && rr) begin
        m_out = 1'b0;
        m_ptr = (m_id + 1) % N;
      end else begin
        m_age++;
      end
    end else if (exp_id >= 0) begin
      a          = l[exp_id*W +: W];
      b          = r[exp_id*W +: W];
      m_out      = 1'b1;
      m_age      = 1;
      m_id       = exp_id;
      m_sum      = W'((64'(a) + 64'(b)) % (64'd1 << W));
      m_last_lhs = a;
      m_last_rhs = b;
    end
    cyc++;
  endtask

  logic [N*W-1:0] dl, dr;
  int             exp_order[5] = '{0, 1, 2, 3, 0};
  int             cnt0;

  initial begin
    // Reset held with random inputs
    repeat (4) step(4'($urandom_range(0, 15)), rnd_pack(), rnd_pack(), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) step('0, rnd_pack(), rnd_pack(), 1'b1);

    // Round-robin with every requester asserting
    grants.delete();
    grant_cyc.delete();
    repeat (13) step('1, rnd_pack(), rnd_pack(), 1'b1);
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      chk("rr_grant", grants[i], exp_order[i]);
      chk("rr_interval", grant_cyc[i] - grant_cyc[0], 3 * i);
    end
    repeat (3) step('0, rnd_pack(), rnd_pack(), 1'b1);

    // Single op from requester 2
    cnt0 = rsp_count;
    dl = rnd_pack(); dr = rnd_pack();
    dl[2*W +: W] = 32'h0000_0005;
    dr[2*W +: W] = 32'h0000_0007;
    step(4'b0100, dl, dr, 1'b1);
    repeat (3) step('0, rnd_pack(), rnd_pack(), 1'b1);
    chk("single_cnt", rsp_count - cnt0, 1);
    chk("single_id", last_rsp_id, 2);
    chk("single_sum", last_rsp_result, 32'h0000_000C);

    // Carry discarded
    dl = rnd_pack(); dr = rnd_pack();
    dl[1*W +: W] = 32'hFFFF_FFFF;
    dr[1*W +: W] = 32'h0000_0002;
    step(4'b0010, dl, dr, 1'b1);
    repeat (3) step('0, rnd_pack(), rnd_pack(), 1'b1);
    chk("wrap_id", last_rsp_id, 1);
    chk("wrap_sum", last_rsp_result, 32'h0000_0001);

    // Backpressure: response held for 10 cycles while others keep requesting
    cnt0 = rsp_count;
    step(4'b1000, rnd_pack(), rnd_pack(), 1'b0);
    step('1, rnd_pack(), rnd_pack(), 1'b0);
    repeat (10) step(4'($urandom_range(0, 15)), rnd_pack(), rnd_pack(), 1'b0);
    chk("bp_held", rsp_count - cnt0, 0);
    step('1, rnd_pack(), rnd_pack(), 1'b1);
    chk("bp_done", rsp_count - cnt0, 1);
    chk("bp_id", last_rsp_id, 3);
    repeat (4) step('0, rnd_pack(), rnd_pack(), 1'b1);

    // Randomized traffic with random backpressure
    repeat (400)
      step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), rnd_pack(), rnd_pack(),
           1'($urandom_range(0, 3) != 0));
    repeat (4) step('0, rnd_pack(), rnd_pack(), 1'b1);

    // Asynchronous reset while in EXEC
    dl = rnd_pack(); dr = rnd_pack();
    dl[1*W +: W] = 32'h1234_5678;
    step(4'b0010, dl, dr, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_req_ready", req_ready, '0);
    chk("arst_add_lhs", add_lhs, '0);
    chk("arst_add_rhs", add_rhs, '0);
    model_reset();
    cnt0 = rsp_count;
    repeat (2) step('1, rnd_pack(), rnd_pack(), 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) step('0, rnd_pack(), rnd_pack(), 1'b1);
    chk("arst_no_rsp", rsp_count - cnt0, 0);
    grants.delete();
    grant_cyc.delete();
    step('1, rnd_pack(), rnd_pack(), 1'b1);
    chk("arst_grant_cnt", grants.size(), 1);
    if (grants.size() > 0) chk("arst_ptr0", grants[0], 0);
    repeat (4) step('0, rnd_pack(), rnd_pack(), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
